map_walker: RTL and testbench
=============================

MAP_WALKER -- requirements
Module: map_walker

Interface
REQ-001 Parameter MAP_W, default 64, map width in tiles.
REQ-002 Parameter MAP_H, default 64, map height in tiles.
REQ-003 Parameter SPAWN_X / SPAWN_Y, default 8 / 8, tile position after reset.
REQ-004 Parameter BUMP_FRAMES, default 8, frames spent in a blocked-step bump.
REQ-005 Clk  in  1  system clock.
REQ-006 Reset  in  1  reset: synchronous, active-high.
REQ-007 frame_tick  in  1  one-Clk pulse per VGA frame.
REQ-008 state_num  in  4  game state code; 3 = main game.
REQ-009 charIsMoving  in  1  movement key held.
REQ-010 charIsRunning  in  1  run modifier.
REQ-011 direction  in  2  0 down, 1 up, 2 left, 3 right.
REQ-012 coll_req  out  1  collision lookup request.
REQ-013 coll_tx / coll_ty  out  6 / 6  tile being queried.
REQ-014 coll_ack  in  1  lookup done, one-Clk pulse.
REQ-015 coll_blocked  in  1  target impassable; valid only with coll_ack.
REQ-016 tile_x / tile_y  out  6 / 6  committed player tile.
REQ-017 step_offset  out  5  pixels travelled into current step, 0..16.
REQ-018 step_dir  out  2  direction of current step or bump.
REQ-019 step_active  out  1  high in STEP.
REQ-020 bumping  out  1  high in BUMP.

Function
REQ-021 FSM states IDLE, QUERY, STEP, BUMP; all transitions on Clk.
REQ-022 IDLE -> on frame_tick with state_num==3 and charIsMoving: latch direction into step_dir, latch charIsRunning as speed (1 px walk, 2 px run), compute target = tile +/- 1 on the direction axis.
REQ-023 Target outside 0..MAP_W-1 / 0..MAP_H-1 (incl. underflow from 0) -> BUMP directly, no lookup.
REQ-024 Otherwise -> QUERY: coll_req high, coll_tx/coll_ty = target, both held stable until coll_ack sampled high; coll_req low the cycle after ack.
REQ-025 Ack with coll_blocked=1 -> BUMP; ack with coll_blocked=0 -> STEP, step_offset=0.
REQ-026 STEP: each frame_tick, step_offset += speed; when result >=16, tile_x/tile_y <= target, step_offset <= 0, -> IDLE in the same cycle.
REQ-027 Step duration exactly 16 ticks walking, 8 running; speed and direction frozen for the whole step regardless of inputs.
REQ-028 BUMP: count BUMP_FRAMES frame_ticks, position unchanged, then -> IDLE.
REQ-029 state_num != 3 in any state -> IDLE next cycle, coll_req low, step_offset 0, tile unchanged (aborted step not committed); late coll_ack ignored.
REQ-030 frame_tick coincident with coll_ack in QUERY: ack takes effect, tick not counted toward STEP.
REQ-031 A new step only starts on a frame_tick in IDLE; held movement yields back-to-back steps with one idle tick between.
REQ-032 coll_ack outside QUERY ignored.

Reset
REQ-033 On Reset: state IDLE, tile_x=SPAWN_X, tile_y=SPAWN_Y, step_offset 0, step_dir 0, coll_req 0, step_active 0, bumping 0, bump counter 0.
REQ-034 Reset mid-QUERY or mid-STEP discards the pending step; no commit.

Structure
REQ-035 Shared package game_pkg holds direction enum (DIR_DOWN..DIR_RIGHT), TILE_PX=16, STATE_MAIN_GAME=3, WALK_SPEED=1, RUN_SPEED=2.
REQ-036 One sub-module, tile_target_calc: combinational tile+direction -> target and out_of_bounds flag.

Verification
REQ-037 Reset, state_num=3, moving, dir=3, ack blocked=0 at 2 Clk -> 16 ticks later tile_x 8->9, step_offset 1..15 then 0.
REQ-038 Running, dir=1 -> step_offset 2,4..14, commit tile_y 8->7 after 8 ticks.
REQ-039 Ack blocked=1 -> bumping for 8 ticks, tile unchanged, then IDLE.
REQ-040 Tile_x=0, dir=2 -> no coll_req, direct BUMP.
REQ-041 state_num 3->0 at step_offset 6 -> IDLE, offset 0, tile unchanged; late ack ignored.
REQ-042 coll_ack delayed 5 Clk -> coll_req and coll_tx/coll_ty held stable throughout.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants: direction encoding, tile geometry and movement speeds.
package game_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    localparam logic [4:0] TILE_PX         = 5'd16;
    localparam logic [3:0] STATE_MAIN_GAME = 4'd3;
    localparam logic [4:0] WALK_SPEED      = 5'd1;
    localparam logic [4:0] RUN_SPEED       = 5'd2;

endpackage

// File: rtl/tile_target_calc.sv
// Neighbouring tile in a given direction, flagging moves that leave the map.
module tile_target_calc
    import game_pkg::*;
#(
    parameter int unsigned MAP_W = 64,
    parameter int unsigned MAP_H = 64
) (
    input  logic [5:0] tile_x,
    input  logic [5:0] tile_y,
    input  logic [1:0] dir,
    output logic [5:0] target_x,
    output logic [5:0] target_y,
    output logic       out_of_bounds
);

    // One extra bit so that 63 + 1 is still compared correctly against a 64-wide map.
    localparam logic [6:0] MaxX = 7'(MAP_W);
    localparam logic [6:0] MaxY = 7'(MAP_H);

    always_comb begin
        target_x      = tile_x;
        target_y      = tile_y;
        out_of_bounds = 1'b0;
        unique case (dir_e'(dir))
            DIR_DOWN: begin
                target_y      = tile_y + 6'd1;
                out_of_bounds = ({1'b0, tile_y} + 7'd1) >= MaxY;
            end
            DIR_UP: begin
                target_y      = tile_y - 6'd1;
                out_of_bounds = (tile_y == 6'd0);
            end
            DIR_LEFT: begin
                target_x      = tile_x - 6'd1;
                out_of_bounds = (tile_x == 6'd0);
            end
            DIR_RIGHT: begin
                target_x      = tile_x + 6'd1;
                out_of_bounds = ({1'b0, tile_x} + 7'd1) >= MaxX;
            end
        endcase
    end

endmodule

// File: rtl/map_walker.sv
// Tile-based player movement: collision lookup, 16-pixel step animation and blocked-step bump.
module map_walker
    import game_pkg::*;
#(
    parameter int unsigned MAP_W       = 64,
    parameter int unsigned MAP_H       = 64,
    parameter int unsigned SPAWN_X     = 8,
    parameter int unsigned SPAWN_Y     = 8,
    parameter int unsigned BUMP_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [3:0] state_num,
    input  logic       charIsMoving,
    input  logic       charIsRunning,
    input  logic [1:0] direction,
    output logic       coll_req,
    output logic [5:0] coll_tx,
    output logic [5:0] coll_ty,
    input  logic       coll_ack,
    input  logic       coll_blocked,
    output logic [5:0] tile_x,
    output logic [5:0] tile_y,
    output logic [4:0] step_offset,
    output logic [1:0] step_dir,
    output logic       step_active,
    output logic       bumping
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StQuery = 2'd1;
    localparam logic [1:0] StStep  = 2'd2;
    localparam logic [1:0] StBump  = 2'd3;

    localparam int unsigned BumpW    = (BUMP_FRAMES < 2) ? 1 : $clog2(BUMP_FRAMES + 1);
    localparam logic [BumpW-1:0] BumpLast = BumpW'(BUMP_FRAMES - 1);

    logic [1:0]       state_q, state_d;
    logic [5:0]       tile_x_q, tile_x_d, tile_y_q, tile_y_d;
    logic [5:0]       tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [4:0]       offset_q, offset_d;
    logic [1:0]       dir_q, dir_d;
    logic             run_q, run_d;
    logic [BumpW-1:0] bump_cnt_q, bump_cnt_d;

    logic [5:0] calc_x, calc_y;
    logic       calc_oob;
    logic       in_game;
    logic [4:0] speed, offset_sum;

    tile_target_calc #(
        .MAP_W(MAP_W),
        .MAP_H(MAP_H)
    ) u_target (
        .tile_x       (tile_x_q),
        .tile_y       (tile_y_q),
        .dir          (direction),
        .target_x     (calc_x),
        .target_y     (calc_y),
        .out_of_bounds(calc_oob)
    );

    assign in_game    = (state_num == STATE_MAIN_GAME);
    assign speed      = run_q ? RUN_SPEED : WALK_SPEED;
    assign offset_sum = offset_q + speed;

    always_comb begin
        state_d    = state_q;
        tile_x_d   = tile_x_q;
        tile_y_d   = tile_y_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        offset_d   = offset_q;
        dir_d      = dir_q;
        run_d      = run_q;
        bump_cnt_d = bump_cnt_q;

        if (!in_game) begin
            // Leaving the main game abandons any step in flight without committing it.
            state_d    = StIdle;
            offset_d   = 5'd0;
            bump_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (frame_tick && charIsMoving) begin
                        dir_d      = direction;
                        run_d      = charIsRunning;
                        tgt_x_d    = calc_x;
                        tgt_y_d    = calc_y;
                        offset_d   = 5'd0;
                        bump_cnt_d = '0;
                        state_d    = calc_oob ? StBump : StQuery;
                    end
                end
                StQuery: begin
                    // A frame_tick arriving with the ack is not counted toward the step.
                    if (coll_ack) begin
                        offset_d = 5'd0;
                        state_d  = coll_blocked ? StBump : StStep;
                    end
                end
                StStep: begin
                    if (frame_tick) begin
                        if (offset_sum >= TILE_PX) begin
                            tile_x_d = tgt_x_q;
                            tile_y_d = tgt_y_q;
                            offset_d = 5'd0;
                            state_d  = StIdle;
                        end else begin
                            offset_d = offset_sum;
                        end
                    end
                end
                StBump: begin
                    if (frame_tick) begin
                        if (bump_cnt_q == BumpLast) begin
                            bump_cnt_d = '0;
                            state_d    = StIdle;
                        end else begin
                            bump_cnt_d = bump_cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            tile_x_q   <= 6'(SPAWN_X);
            tile_y_q   <= 6'(SPAWN_Y);
            tgt_x_q    <= 6'(SPAWN_X);
            tgt_y_q    <= 6'(SPAWN_Y);
            offset_q   <= 5'd0;
            dir_q      <= 2'd0;
            run_q      <= 1'b0;
            bump_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tile_x_q   <= tile_x_d;
            tile_y_q   <= tile_y_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            offset_q   <= offset_d;
            dir_q      <= dir_d;
            run_q      <= run_d;
            bump_cnt_q <= bump_cnt_d;
        end
    end

    assign coll_req    = (state_q == StQuery);
    assign coll_tx     = tgt_x_q;
    assign coll_ty     = tgt_y_q;
    assign tile_x      = tile_x_q;
    assign tile_y      = tile_y_q;
    assign step_offset = offset_q;
    assign step_dir    = dir_q;
    assign step_active = (state_q == StStep);
    assign bumping     = (state_q == StBump);

endmodule

// File: tb/tb_map_walker.sv
// Bench for map_walker: directed scenarios plus random traffic against a tick-counting model.
module tb_map_walker;

    localparam int MAP_W   = 64;
    localparam int MAP_H   = 64;
    localparam int SPAWN_X = 8;
    localparam int SPAWN_Y = 8;
    localparam int BUMP_N  = 8;

    localparam int M_IDLE  = 0;
    localparam int M_QUERY = 1;
    localparam int M_STEP  = 2;
    localparam int M_BUMP  = 3;

    logic       Clk = 1'b0;
    logic       Reset, frame_tick, charIsMoving, charIsRunning, coll_ack, coll_blocked;
    logic [3:0] state_num;
    logic [1:0] direction;
    logic       coll_req, step_active, bumping;
    logic [5:0] coll_tx, coll_ty, tile_x, tile_y;
    logic [4:0] step_offset;
    logic [1:0] step_dir;

    int total = 0;
    int bad   = 0;

    // Model: position, pending target, ticks elapsed in the current step or bump.
    int m_x, m_y, m_tx, m_ty, m_mode, m_ticks, m_bump, m_speed, m_dir;

    map_walker #(
        .MAP_W(MAP_W), .MAP_H(MAP_H), .SPAWN_X(SPAWN_X), .SPAWN_Y(SPAWN_Y), .BUMP_FRAMES(BUMP_N)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .state_num(state_num),
        .charIsMoving(charIsMoving), .charIsRunning(charIsRunning), .direction(direction),
        .coll_req(coll_req), .coll_tx(coll_tx), .coll_ty(coll_ty), .coll_ack(coll_ack),
        .coll_blocked(coll_blocked), .tile_x(tile_x), .tile_y(tile_y),
        .step_offset(step_offset), .step_dir(step_dir), .step_active(step_active),
        .bumping(bumping)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit tick, input int sn, input bit mv,
                              input bit run, input int dir, input bit ack, input bit blk);
        int dx, dy;
        if (rst) begin
            m_x = SPAWN_X; m_y = SPAWN_Y; m_mode = M_IDLE; m_ticks = 0; m_bump = 0; m_dir = 0;
            m_speed = 1;
        end else if (sn != 3) begin
            m_mode = M_IDLE; m_ticks = 0; m_bump = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (tick && mv) begin
                    m_dir = dir; m_speed = run ? 2 : 1; m_ticks = 0; m_bump = 0;
                    dx = (dir == 2) ? -1 : (dir == 3) ? 1 : 0;
                    dy = (dir == 1) ? -1 : (dir == 0) ? 1 : 0;
                    m_tx = m_x + dx; m_ty = m_y + dy;
                    if (m_tx < 0 || m_tx >= MAP_W || m_ty < 0 || m_ty >= MAP_H) m_mode = M_BUMP;
                    else m_mode = M_QUERY;
                end
                M_QUERY: if (ack) m_mode = blk ? M_BUMP : M_STEP;
                M_STEP: if (tick) begin
                    m_ticks++;
                    if (m_ticks * m_speed >= 16) begin
                        m_x = m_tx; m_y = m_ty; m_ticks = 0; m_mode = M_IDLE;
                    end
                end
                default: if (tick) begin
                    m_bump++;
                    if (m_bump == BUMP_N) begin m_bump = 0; m_mode = M_IDLE; end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        check("tile_x", int'(tile_x), m_x);
        check("tile_y", int'(tile_y), m_y);
        check("step_offset", int'(step_offset), (m_mode == M_STEP) ? m_ticks * m_speed : 0);
        check("step_dir", int'(step_dir), m_dir);
        check("step_active", int'(step_active), int'(m_mode == M_STEP));
        check("bumping", int'(bumping), int'(m_mode == M_BUMP));
        check("coll_req", int'(coll_req), int'(m_mode == M_QUERY));
        if (m_mode == M_QUERY) begin
            check("coll_tx", int'(coll_tx), m_tx);
            check("coll_ty", int'(coll_ty), m_ty);
        end
    endtask

    task automatic cycle(input bit rst, input bit tick, input int sn, input bit mv, input bit run,
                         input int dir, input bit ack, input bit blk);
        Reset = rst; frame_tick = tick; state_num = 4'(sn); charIsMoving = mv;
        charIsRunning = run; direction = 2'(dir); coll_ack = ack; coll_blocked = blk;
        @(posedge Clk);
        model_step(rst, tick, sn, mv, run, dir, ack, blk);
        #1;
        compare_all();
    endtask

    // Start a step, wait `delay` query cycles, ack, then tick every cycle until idle.
    task automatic do_step(input bit run, input int dir, input bit blk, input int delay,
                           output int bump_cycles);
        bump_cycles = 0;
        cycle(0, 1, 3, 1, run, dir, 0, 0);
        if (m_mode == M_QUERY) begin
            for (int i = 0; i < delay; i++) cycle(0, 0, 3, 0, 0, 0, 0, 0);
            cycle(0, 0, 3, 0, 0, 0, 1, blk);
        end
        if (bumping) bump_cycles++;
        for (int i = 0; i < 40 && m_mode != M_IDLE; i++) begin
            cycle(0, 1, 3, 0, ~run, 3 - dir, 0, 0);
            if (bumping) bump_cycles++;
        end
        check("step_done", int'(step_active | bumping | coll_req), 0);
    endtask

    initial begin
        int bc;
        bit tk, mv, rs, ak, bk;
        int sn;

        cycle(1, 0, 3, 0, 0, 0, 0, 0);
        cycle(1, 1, 3, 1, 1, 2, 1, 0);
        check("rst_tile_x", int'(tile_x), 8);
        check("rst_tile_y", int'(tile_y), 8);

        do_step(0, 3, 0, 1, bc);
        check("walk_right_x", int'(tile_x), 9);
        do_step(1, 1, 0, 0, bc);
        check("run_up_y", int'(tile_y), 7);
        do_step(0, 2, 1, 2, bc);
        check("bump_len", bc, 8);
        check("bump_tile_x", int'(tile_x), 9);

        for (int i = 0; i < 9; i++) do_step(i[0], 2, 0, 0, bc);
        check("edge_x", int'(tile_x), 0);
        cycle(0, 1, 3, 1, 0, 2, 0, 0);
        check("edge_no_req", int'(coll_req), 0);
        check("edge_bump", int'(bumping), 1);
        for (int i = 0; i < 8; i++) cycle(0, 1, 3, 0, 0, 0, 0, 0);

        cycle(0, 1, 3, 1, 0, 3, 0, 0);
        cycle(0, 0, 3, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 3, 1, 1, 0, 0, 0);
        check("abort_pre_off", int'(step_offset), 6);
        cycle(0, 0, 0, 1, 0, 3, 0, 0);
        check("abort_off", int'(step_offset), 0);
        check("abort_active", int'(step_active), 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 3, 0, 0, 0, 1, 0);
        check("abort_tile_x", int'(tile_x), 0);

        cycle(0, 1, 3, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, i[0], 3, 1, 1, 2, 0, 0);
            check("hold_req", int'(coll_req), 1);
            check("hold_tx", int'(coll_tx), 0);
            check("hold_ty", int'(coll_ty), 8);
        end
        cycle(0, 1, 3, 0, 0, 0, 1, 0);
        for (int i = 0; i < 40 && m_mode != M_IDLE; i++) cycle(0, 1, 3, 0, 0, 0, 0, 0);
        check("delayed_ack_y", int'(tile_y), 8);

        for (int i = 0; i < 5000; i++) begin
            rs = ($urandom % 600) == 0;
            tk = ($urandom % 3) == 0;
            sn = (($urandom % 50) == 0) ? int'($urandom % 16) : 3;
            mv = ($urandom % 8) != 0;
            ak = (m_mode == M_QUERY) ? (($urandom % 3) == 0) : (($urandom % 15) == 0);
            bk = ($urandom % 4) == 0;
            cycle(rs, tk, sn, mv, 1'($urandom), int'($urandom % 4), ak, bk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
